// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_pkg
//  Description : Shared helpers for the pipelined posit decoder. Derives the
//                regime, exponent and fraction widths from the posit word
//                width N and exponent width ES. Also provides a decoded-posit
//                struct for the default N=64 / ES=4 configuration.
//  Revision    : 1.0  initial pipelined, N/ES-generic release
// ============================================================================
package posit_pkg;

   // Signed width of the regime value k. The magnitude of k is at most N-1,
   // so one bit beyond $clog2(N-1) is needed for the sign.
   function automatic int calc_kw(input int n);
      return $clog2(n - 1) + 1;
   endfunction

   // Fraction width: the word minus the sign, the shortest regime (2 bits)
   // and the exponent.
   function automatic int calc_fs(input int n, input int es);
      return n - es - 3;
   endfunction

   // The exponent port keeps at least one bit so that ES=0 still elaborates.
   function automatic int calc_ew(input int es);
      return (es > 0) ? es : 1;
   endfunction

   localparam int DEF_N  = 64;
   localparam int DEF_ES = 4;
   localparam int DEF_KW = calc_kw(DEF_N);
   localparam int DEF_FS = calc_fs(DEF_N, DEF_ES);
   localparam int DEF_EW = calc_ew(DEF_ES);

   typedef struct packed {
      logic              sign;
      logic [DEF_KW-1:0] k;
      logic [DEF_EW-1:0] exp;
      logic [DEF_FS-1:0] frac;
      logic              zero;
      logic              nar;
   } posit_dec_t;

endpackage : posit_pkg
`default_nettype wire

// File: rtl/posit_run_detect.sv
`default_nettype none
// ============================================================================
//  Module      : posit_run_detect
//  Description : Combinational leading-run counter. Counts how many bits,
//                starting at the MSB, are equal to the MSB. The result is in
//                the range 1..W; W means that the whole vector is one run.
//  Ports       : vec_i  [W-1:0]   vector to scan (MSB first)
//                run_o  [KW-1:0]  length of the leading run
//                pol_o            polarity of the run (value of the MSB)
//  Revision    : 1.0  initial release
// ============================================================================
module posit_run_detect #(
   parameter int W  = 63,
   parameter int KW = 7
) (
   input  logic [W-1:0]  vec_i,
   output logic [KW-1:0] run_o,
   output logic          pol_o
);

   assign pol_o = vec_i[W-1];

   // Scan from the LSB upwards. The last bit that differs from the MSB wins,
   // which is the highest one, so it marks the end of the leading run.
   always_comb begin
      run_o = KW'(W);
      for (int i = 0; i <= W - 2; i++) begin
         if (vec_i[i] != vec_i[W-1]) begin
            run_o = KW'(W - 1 - i);
         end
      end
   end

endmodule : posit_run_detect
`default_nettype wire

// File: rtl/posit_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : posit_decoder_pipe
//  Description : Three-stage pipelined posit decoder with valid/ready flow
//                control. Splits an N-bit posit into sign, signed regime k,
//                exponent and MSB-aligned fraction, and flags zero and NaR.
//                  S1: sign, zero/NaR flags, magnitude x (two's complement of
//                      the low N-1 bits when negative)
//                  S2: leading-run detect, regime value k, remainder
//                  S3: exponent/fraction extraction (output registers)
//                A single global stall (out_valid & ~out_ready) freezes every
//                stage; otherwise all stages advance together.
//  Ports       : clk, rst                    clock, async active-high reset
//                in_valid/in_ready/in_posit  input handshake and word
//                out_valid/out_ready         output handshake
//                out_sign, out_k, out_exp,
//                out_frac, out_zero, out_nar decoded fields
//  Revision    : 1.0  initial pipelined, N/ES-generic release
// ============================================================================
module posit_decoder_pipe
   import posit_pkg::*;
#(
   parameter int N  = 64,
   parameter int ES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N-1:0]              in_posit,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_sign,
   output logic [calc_kw(N)-1:0]     out_k,
   output logic [calc_ew(ES)-1:0]    out_exp,
   output logic [calc_fs(N,ES)-1:0]  out_frac,
   output logic                      out_zero,
   output logic                      out_nar
);

   // Derived widths; these follow from N and ES and are not overridable.
   localparam int KW   = calc_kw(N);
   localparam int FS   = calc_fs(N, ES);
   localparam int EW   = calc_ew(ES);
   localparam int XW   = N - 1;       // magnitude width (word without sign)
   localparam int REMW = N - 3;       // exponent + fraction after the regime

   // ------------------------------------------------------------------------
   // Flow control
   // ------------------------------------------------------------------------
   logic stall;
   logic advance;
   logic s3_valid_q;

   assign stall    = s3_valid_q & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = advance;

   // ------------------------------------------------------------------------
   // Stage 1: sign, special-value flags, magnitude
   // ------------------------------------------------------------------------
   logic          s1_valid_q;
   logic          s1_sign_q;
   logic          s1_zero_q;
   logic          s1_nar_q;
   logic [XW-1:0] s1_x_q;

   logic          s1_zero_d;
   logic          s1_nar_d;
   logic [XW-1:0] s1_x_d;

   // The negation wraps at N-1 bits, so NaR (1 followed by zeros) maps to
   // x = 0 just like zero does; both are then masked by their flags.
   always_comb begin
      s1_zero_d = (in_posit == '0);
      s1_nar_d  = in_posit[N-1] & (in_posit[N-2:0] == '0);
      s1_x_d    = in_posit[N-1] ? (XW'(0) - in_posit[N-2:0]) : in_posit[N-2:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_nar_q   <= 1'b0;
         s1_x_q     <= '0;
      end else if (advance) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= in_posit[N-1];
            s1_zero_q <= s1_zero_d;
            s1_nar_q  <= s1_nar_d;
            s1_x_q    <= s1_x_d;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: regime decode
   // ------------------------------------------------------------------------
   logic            run_len;
   logic [KW-1:0]   run;
   logic            pol;

   posit_run_detect #(
      .W  (XW),
      .KW (KW)
   ) u_run_detect (
      .vec_i (s1_x_q),
      .run_o (run),
      .pol_o (pol)
   );

   logic            s2_valid_q;
   logic            s2_sign_q;
   logic            s2_zero_q;
   logic            s2_nar_q;
   logic [KW-1:0]   s2_k_q;
   logic [REMW-1:0] s2_rem_q;

   logic [KW-1:0]   s2_k_d;
   logic [XW-1:0]   s2_shift;
   logic [REMW-1:0] s2_rem_d;
   logic [1:0]      unused_shift_lsb;

   assign run_len = 1'b0;

   // The shift drops the regime run plus its terminator. When the run fills
   // the whole magnitude the shift reaches past the word and yields zero,
   // which also zero-fills a truncated exponent. The shift is always at least
   // two, so the two LSBs of the shifted vector are always zero.
   always_comb begin
      s2_k_d   = pol ? (run - KW'(1)) : (KW'(0) - run);
      s2_shift = s1_x_q << (run + KW'(1));
      s2_rem_d = s2_shift[XW-1:2];
      if (s1_zero_q | s1_nar_q) begin
         s2_k_d = '0;
      end
   end

   assign unused_shift_lsb = {s2_shift[1] ^ run_len, s2_shift[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_nar_q   <= 1'b0;
         s2_k_q     <= '0;
         s2_rem_q   <= '0;
      end else if (advance) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s1_zero_q;
            s2_nar_q  <= s1_nar_q;
            s2_k_q    <= s2_k_d;
            s2_rem_q  <= s2_rem_d;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 3: exponent / fraction split (output registers)
   // ------------------------------------------------------------------------
   logic [EW-1:0] s3_exp_d;
   logic [FS-1:0] s3_frac_d;

   generate
      if (ES > 0) begin : g_exp
         assign s3_exp_d = s2_rem_q[REMW-1 -: ES];
      end else begin : g_no_exp
         assign s3_exp_d = '0;
      end
   endgenerate

   // Zero and NaR arrive with a zero remainder (x = 0), so exponent and
   // fraction are already zero for them without extra masking.
   assign s3_frac_d = s2_rem_q[FS-1:0];

   logic          s3_sign_q;
   logic          s3_zero_q;
   logic          s3_nar_q;
   logic [KW-1:0] s3_k_q;
   logic [EW-1:0] s3_exp_q;
   logic [FS-1:0] s3_frac_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid_q <= 1'b0;
         s3_sign_q  <= 1'b0;
         s3_zero_q  <= 1'b0;
         s3_nar_q   <= 1'b0;
         s3_k_q     <= '0;
         s3_exp_q   <= '0;
         s3_frac_q  <= '0;
      end else if (advance) begin
         s3_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            s3_sign_q <= s2_sign_q;
            s3_zero_q <= s2_zero_q;
            s3_nar_q  <= s2_nar_q;
            s3_k_q    <= s2_k_q;
            s3_exp_q  <= s3_exp_d;
            s3_frac_q <= s3_frac_d;
         end
      end
   end

   assign out_valid = s3_valid_q;
   assign out_sign  = s3_sign_q;
   assign out_k     = s3_k_q;
   assign out_exp   = s3_exp_q;
   assign out_frac  = s3_frac_q;
   assign out_zero  = s3_zero_q;
   assign out_nar   = s3_nar_q;

endmodule : posit_decoder_pipe
`default_nettype wire

// File: tb/tb_posit_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_decoder_pipe
//  Description : Self-checking bench for posit_decoder_pipe. Exercises an
//                N=16/ES=1 instance with directed vectors, back-pressure and
//                asynchronous reset, and an N=64/ES=4 instance with a random
//                stream compared against a bit-walking reference decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_posit_decoder_pipe;

   typedef struct packed {
      logic               sign;
      logic signed [31:0] k;
      logic [31:0]        exp;
      logic [63:0]        frac;
      logic               zero;
      logic               nar;
   } ref_t;

   logic clk;
   logic rst;

   // N=16, ES=1 instance
   logic        in16_valid, in16_ready, out16_valid, out16_ready;
   logic [15:0] in16_posit;
   logic        out16_sign, out16_zero, out16_nar;
   logic [4:0]  out16_k;
   logic [0:0]  out16_exp;
   logic [11:0] out16_frac;

   // N=64, ES=4 instance
   logic        in64_valid, in64_ready, out64_valid, out64_ready;
   logic [63:0] in64_posit;
   logic        out64_sign, out64_zero, out64_nar;
   logic [6:0]  out64_k;
   logic [3:0]  out64_exp;
   logic [56:0] out64_frac;

   int n_checks;
   int n_errors;

   posit_decoder_pipe #(.N(16), .ES(1)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in16_valid), .in_ready(in16_ready), .in_posit(in16_posit),
      .out_valid(out16_valid), .out_ready(out16_ready),
      .out_sign(out16_sign), .out_k(out16_k), .out_exp(out16_exp),
      .out_frac(out16_frac), .out_zero(out16_zero), .out_nar(out16_nar)
   );

   posit_decoder_pipe #(.N(64), .ES(4)) u_dut64 (
      .clk(clk), .rst(rst),
      .in_valid(in64_valid), .in_ready(in64_ready), .in_posit(in64_posit),
      .out_valid(out64_valid), .out_ready(out64_ready),
      .out_sign(out64_sign), .out_k(out64_k), .out_exp(out64_exp),
      .out_frac(out64_frac), .out_zero(out64_zero), .out_nar(out64_nar)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decoder: walks the bits of the N-bit word one at a time.
   function automatic ref_t ref_decode(input logic [63:0] p_in, input int n, input int es);
      ref_t        r;
      logic [63:0] mask, p, mag;
      int          pos, run, fs;
      logic        pol, b;
      r    = '0;
      fs   = n - es - 3;
      mask = (64'd1 << n) - 64'd1;
      if (n == 64) mask = '1;
      p    = p_in & mask;
      if (p == 64'd0) begin
         r.zero = 1'b1;
         return r;
      end
      if (p == (64'd1 << (n - 1))) begin
         r.sign = 1'b1;
         r.nar  = 1'b1;
         return r;
      end
      r.sign = p[n-1];
      mag    = r.sign ? ((~p + 64'd1) & mask) : p;
      pol    = mag[n-2];
      run    = 0;
      pos    = n - 2;
      while (pos >= 0 && mag[pos] == pol) begin
         run++;
         pos--;
      end
      r.k = pol ? (run - 1) : -run;
      pos--;                                  // skip the terminator bit
      for (int j = 0; j < es; j++) begin
         b     = (pos >= 0) ? mag[pos] : 1'b0;
         r.exp = (r.exp << 1) | 32'(b);
         pos--;
      end
      for (int j = 0; j < fs; j++) begin
         b      = (pos >= 0) ? mag[pos] : 1'b0;
         r.frac = (r.frac << 1) | 64'(b);
         pos--;
      end
      return r;
   endfunction

   function automatic ref_t mk(input logic s, input int k, input int e,
                               input logic [63:0] f, input logic z, input logic nr);
      ref_t r;
      r.sign = s; r.k = k; r.exp = e; r.frac = f; r.zero = z; r.nar = nr;
      return r;
   endfunction

   function automatic ref_t obs16();
      ref_t r;
      int   kk;
      kk     = $signed(out16_k);
      r.sign = out16_sign; r.k = kk; r.exp = 32'(out16_exp);
      r.frac = 64'(out16_frac); r.zero = out16_zero; r.nar = out16_nar;
      return r;
   endfunction

   function automatic ref_t obs64();
      ref_t r;
      int   kk;
      kk     = $signed(out64_k);
      r.sign = out64_sign; r.k = kk; r.exp = 32'(out64_exp);
      r.frac = 64'(out64_frac); r.zero = out64_zero; r.nar = out64_nar;
      return r;
   endfunction

   function automatic string fmt(input ref_t r);
      return $sformatf("s=%0d k=%0d e=%0d f=%0h z=%0d n=%0d",
                       r.sign, $signed(r.k), r.exp, r.frac, r.zero, r.nar);
   endfunction

   function automatic logic [63:0] gen64();
      logic [63:0] w, t;
      int          sel;
      w   = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      case (sel)
         0: w = 64'd0;
         1: w = 64'h8000_0000_0000_0000;
         2: w = w >> $urandom_range(1, 63);
         3: begin
            t = w >> $urandom_range(1, 63);
            w = {w[63], ~t[62:0]};
         end
         4: w = {w[63], 60'd0, 3'($urandom_range(1, 7))};
         default: ;
      endcase
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({out16_valid, out16_sign, out16_k, out16_exp, out16_frac, out16_zero, out16_nar} !== '0) begin
         n_errors++;
         $display("FAIL reset16_outputs: got valid=%0d %s, expected all zero", out16_valid, fmt(obs16()));
      end
      n_checks++;
      if ({out64_valid, out64_sign, out64_k, out64_exp, out64_frac, out64_zero, out64_nar} !== '0) begin
         n_errors++;
         $display("FAIL reset64_outputs: got valid=%0d %s, expected all zero", out64_valid, fmt(obs64()));
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in16_ready !== 1'b1 || in64_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %0d/%0d, expected 1/1", in16_ready, in64_ready);
      end
   endtask

   task automatic test_vectors();
      logic [15:0] vp [9];
      ref_t        ve [9];
      int          lat;
      vp = '{16'h4000, 16'h5800, 16'hC000, 16'hA800, 16'h8000,
             16'h0000, 16'h7FFF, 16'h0001, 16'h0003};
      ve[0] = mk(0,   0, 0, 64'h000, 0, 0);
      ve[1] = mk(0,   0, 1, 64'h800, 0, 0);
      ve[2] = mk(1,   0, 0, 64'h000, 0, 0);
      ve[3] = mk(1,   0, 1, 64'h800, 0, 0);
      ve[4] = mk(1,   0, 0, 64'h000, 0, 1);
      ve[5] = mk(0,   0, 0, 64'h000, 1, 0);
      ve[6] = mk(0,  14, 0, 64'h000, 0, 0);
      ve[7] = mk(0, -14, 0, 64'h000, 0, 0);   // terminator is the LSB: exponent truncated
      ve[8] = mk(0, -13, 1, 64'h000, 0, 0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         in16_valid  = 1'b1;
         in16_posit  = vp[i];
         out16_ready = 1'b1;
         @(negedge clk);
         in16_valid = 1'b0;
         lat        = 1;
         #1;
         while (!out16_valid && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
         end
         n_checks++;
         if (lat !== 3) begin
            n_errors++;
            $display("FAIL latency_%04h: got %0d cycles, expected 3", vp[i], lat);
         end
         n_checks++;
         if (obs16() !== ve[i]) begin
            n_errors++;
            $display("FAIL vector_%04h: got %s, expected %s", vp[i], fmt(obs16()), fmt(ve[i]));
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] words [3];
      ref_t        got [$];
      ref_t        first;
      words = '{16'h4000, 16'h5800, 16'h7FFF};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in16_valid  = 1'b1;
         in16_posit  = words[i];
         out16_ready = 1'b1;
      end
      @(negedge clk);
      in16_valid  = 1'b0;
      out16_ready = 1'b0;
      #1;
      first = obs16();
      n_checks++;
      if (out16_valid !== 1'b1 || first !== ref_decode(64'(words[0]), 16, 1)) begin
         n_errors++;
         $display("FAIL stall_first: got valid=%0d %s, expected valid=1 %s",
                  out16_valid, fmt(first), fmt(ref_decode(64'(words[0]), 16, 1)));
      end
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         n_checks++;
         if (in16_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_in_ready: cycle %0d got %0d, expected 0", c, in16_ready);
         end
         n_checks++;
         if (out16_valid !== 1'b1 || obs16() !== first) begin
            n_errors++;
            $display("FAIL stall_hold: cycle %0d got valid=%0d %s, expected valid=1 %s",
                     c, out16_valid, fmt(obs16()), fmt(first));
         end
      end
      @(negedge clk);
      out16_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (out16_valid) got.push_back(obs16());
         @(negedge clk);
      end
      n_checks++;
      if (got.size() != 3) begin
         n_errors++;
         $display("FAIL stall_count: got %0d results, expected 3", got.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) begin
            n_checks++;
            if (got[i] !== ref_decode(64'(words[i]), 16, 1)) begin
               n_errors++;
               $display("FAIL stall_order_%0d: got %s, expected %s",
                        i, fmt(got[i]), fmt(ref_decode(64'(words[i]), 16, 1)));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      int stale;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in16_valid  = 1'b1;
         in16_posit  = 16'($urandom_range(1, 16'h7FFF));
         out16_ready = 1'b1;
      end
      @(negedge clk);
      in16_valid = 1'b0;
      #1;
      n_checks++;
      if (out16_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL areset_pre: got out_valid=%0d, expected 1", out16_valid);
      end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out16_valid, out16_sign, out16_k, out16_exp, out16_frac, out16_zero, out16_nar} !== '0) begin
         n_errors++;
         $display("FAIL areset_outputs: got valid=%0d %s, expected all zero", out16_valid, fmt(obs16()));
      end
      n_checks++;
      if (in16_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL areset_in_ready: got %0d, expected 1", in16_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (out16_valid) stale++;
      end
      n_checks++;
      if (stale != 0) begin
         n_errors++;
         $display("FAIL areset_stale: got %0d stale outputs, expected 0", stale);
      end
   endtask

   task automatic test_random64();
      ref_t        q [$];
      ref_t        got, expv, held;
      logic [63:0] p;
      logic        prev_stall;
      int          sent, cyc;
      sent       = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      held       = '0;
      while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         p           = gen64();
         in64_posit  = p;
         in64_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
         out64_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
         #1;
         if (prev_stall) begin
            n_checks++;
            if (out64_valid !== 1'b1 || obs64() !== held) begin
               n_errors++;
               $display("FAIL rand_hold: got valid=%0d %s, expected valid=1 %s",
                        out64_valid, fmt(obs64()), fmt(held));
            end
         end
         if (out64_valid && out64_ready) begin
            got = obs64();
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL rand_unexpected: got %s, expected no output", fmt(got));
            end else begin
               expv = q.pop_front();
               if (got !== expv) begin
                  n_errors++;
                  $display("FAIL rand_word: got %s, expected %s", fmt(got), fmt(expv));
               end
            end
         end
         prev_stall = out64_valid && !out64_ready;
         held       = obs64();
         if (in64_valid && in64_ready) begin
            q.push_back(ref_decode(p, 64, 4));
            sent++;
         end
      end
      in64_valid = 1'b0;
      n_checks++;
      if (sent != 10000 || q.size() != 0) begin
         n_errors++;
         $display("FAIL rand_drain: got sent=%0d pending=%0d, expected 10000/0", sent, q.size());
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      in16_valid  = 1'b0;
      in16_posit  = '0;
      out16_ready = 1'b1;
      in64_valid  = 1'b0;
      in64_posit  = '0;
      out64_ready = 1'b1;
      test_reset();
      test_vectors();
      test_stall();
      test_async_reset();
      test_random64();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_posit_decoder_pipe
`default_nettype wire
